// File: rtl/l2_mem_pkg.sv
// L2 memory bridge shared types: memory map, region encoding
// and the response word carried through the response buffer.
package l2_mem_pkg;

    localparam int SRAM_WORDS = 6144;
    localparam int SCM0_WORDS = 2048;
    localparam int SCM1_WORDS = 2048;
    localparam int SCM0_BASE  = SRAM_WORDS;
    localparam int SCM1_BASE  = SCM0_BASE + SCM0_WORDS;
    localparam int WIN_WORDS  = SCM1_BASE + SCM1_WORDS;

    typedef enum logic [1:0] {
        SRAM,
        SCM0,
        SCM1,
        NONE
    } region_e;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    function automatic region_e decode_region(input logic [29:0] w);
        region_e r;
        if (w < 30'(SCM0_BASE)) begin
            r = SRAM;
        end else if (w < 30'(SCM1_BASE)) begin
            r = SCM0;
        end else if (w < 30'(WIN_WORDS)) begin
            r = SCM1;
        end else begin
            r = NONE;
        end
        return r;
    endfunction

endpackage

// File: rtl/l2_resp_fifo.sv
// Small ordered response buffer; push and pop may coincide,
// including when full, without reordering entries.
module l2_resp_fifo
    import l2_mem_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  push,
    input  resp_t din,
    input  logic  pop,
    output resp_t dout,
    output logic  full,
    output logic  empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    resp_t         mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= nxt(wr_ptr);
            if (do_pop)  rd_ptr <= nxt(rd_ptr);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/l2_mem_bridge.sv
// Bus-to-memory bridge for the L2 window: one SRAM and two SCM
// banks behind a request/grant port with ordered responses.
module l2_mem_bridge
    import l2_mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h1C00_0000,
    parameter int          RESP_DEPTH = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        r_valid_o,
    input  logic        r_ready_i,
    output logic [31:0] r_rdata_o,
    output logic        r_err_o,
    output logic        CEN,
    output logic        CEN_scm0,
    output logic        CEN_scm1,
    output logic        WEN,
    output logic        WEN_scm0,
    output logic        WEN_scm1,
    output logic [3:0]  BEN,
    output logic [3:0]  BEN_scm0,
    output logic [12:0] A,
    output logic [10:0] A_scm0,
    output logic [10:0] A_scm1,
    output logic [31:0] D,
    output logic [31:0] D_scm0,
    input  logic [31:0] Q,
    input  logic [31:0] Q_scm0,
    input  logic [31:0] Q_scm1
);

    logic [29:0] word;
    logic [10:0] scm0_idx;
    logic [10:0] scm1_idx;
    region_e     region;
    logic        acc_err;
    logic        acc_ok;

    logic        inflight_q;
    logic        err_q;
    region_e     bank_q;

    logic [1:0]  fifo_cnt;
    logic [1:0]  occupancy;
    logic        pop_fire;
    logic        fifo_push;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;
    resp_t       rsp_new;
    resp_t       rsp_head;
    resp_t       rsp_out;

    assign word     = addr_i[31:2] - BASE_ADDR[31:2];
    assign scm0_idx = 11'(word - 30'(SCM0_BASE));
    assign scm1_idx = 11'(word - 30'(SCM1_BASE));
    assign region   = (addr_i < BASE_ADDR) ? NONE : decode_region(word);
    assign acc_err  = (region == NONE) || ((region == SCM1) && we_i);

    assign fifo_cnt  = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
    assign occupancy = fifo_cnt + {1'b0, inflight_q};

    assign r_valid_o = !RST && (inflight_q || !fifo_empty);
    assign pop_fire  = r_valid_o && r_ready_i;

    // A pop this cycle frees a slot for the new request.
    assign gnt_o = !RST && req_i &&
                   ((occupancy < 2'd2) ||
                    ((occupancy == 2'd2) && pop_fire));
    assign acc_ok = gnt_o && !acc_err;

    always_comb begin
        CEN      = 1'b1;
        CEN_scm0 = 1'b1;
        CEN_scm1 = 1'b1;
        WEN      = 1'b1;
        WEN_scm0 = 1'b1;
        WEN_scm1 = 1'b1;
        BEN      = 4'hF;
        BEN_scm0 = 4'hF;
        A        = '0;
        A_scm0   = '0;
        A_scm1   = '0;
        D        = '0;
        D_scm0   = '0;
        if (acc_ok) begin
            unique case (region)
                SRAM: begin
                    CEN = 1'b0;
                    WEN = ~we_i;
                    BEN = ~be_i;
                    A   = word[12:0];
                    D   = wdata_i;
                end
                SCM0: begin
                    CEN_scm0 = 1'b0;
                    WEN_scm0 = ~we_i;
                    BEN_scm0 = ~be_i;
                    A_scm0   = scm0_idx;
                    D_scm0   = wdata_i;
                end
                SCM1: begin
                    CEN_scm1 = 1'b0;
                    WEN_scm1 = ~we_i;
                    A_scm1   = scm1_idx;
                end
                default: ;
            endcase
        end
    end

    // Writes and errors carry NONE so their response data is zero.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            inflight_q <= 1'b0;
            err_q      <= 1'b0;
            bank_q     <= NONE;
        end else begin
            inflight_q <= gnt_o;
            err_q      <= gnt_o && acc_err;
            bank_q     <= (acc_ok && !we_i) ? region : NONE;
        end
    end

    always_comb begin
        rsp_new = '{rdata: '0, err: err_q};
        unique case (bank_q)
            SRAM:    rsp_new.rdata = Q;
            SCM0:    rsp_new.rdata = Q_scm0;
            SCM1:    rsp_new.rdata = Q_scm1;
            default: rsp_new.rdata = '0;
        endcase
    end

    // Empty buffer is bypassed so a read answers the cycle after grant.
    assign fifo_pop  = !fifo_empty && r_ready_i;
    assign fifo_push = inflight_q && !(fifo_empty && r_ready_i);
    assign rsp_out   = fifo_empty ? rsp_new : rsp_head;

    assign r_rdata_o = r_valid_o ? rsp_out.rdata : '0;
    assign r_err_o   = r_valid_o && rsp_out.err;

    l2_resp_fifo #(
        .DEPTH (RESP_DEPTH)
    ) u_resp_fifo (
        .clk   (CLK),
        .rst   (RST),
        .push  (fifo_push),
        .din   (rsp_new),
        .pop   (fifo_pop),
        .dout  (rsp_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_l2_mem_bridge.sv
// Bench for l2_mem_bridge: bank models, reference memory and
// an in-order response scoreboard.
module tb_l2_mem_bridge;

    localparam logic [31:0] BASE = 32'h1C00_0000;

    logic        CLK = 1'b0;
    logic        RST;
    logic        req_i;
    logic        gnt_o;
    logic [31:0] addr_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] wdata_i;
    logic        r_valid_o;
    logic        r_ready_i;
    logic [31:0] r_rdata_o;
    logic        r_err_o;
    logic        CEN, CEN_scm0, CEN_scm1;
    logic        WEN, WEN_scm0, WEN_scm1;
    logic [3:0]  BEN, BEN_scm0;
    logic [12:0] A;
    logic [10:0] A_scm0, A_scm1;
    logic [31:0] D, D_scm0;
    logic [31:0] Q, Q_scm0, Q_scm1;

    typedef struct {
        logic [31:0] d;
        logic        e;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_mem [10240];
    logic [31:0] sram_m [6144];
    logic [31:0] scm0_m [2048];
    logic [31:0] scm1_m [2048];

    int checks = 0;
    int errors = 0;
    int rdy_mode = 0;

    always #5 CLK = ~CLK;

    l2_mem_bridge dut (
        .CLK(CLK), .RST(RST),
        .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i), .we_i(we_i),
        .be_i(be_i), .wdata_i(wdata_i),
        .r_valid_o(r_valid_o), .r_ready_i(r_ready_i),
        .r_rdata_o(r_rdata_o), .r_err_o(r_err_o),
        .CEN(CEN), .CEN_scm0(CEN_scm0), .CEN_scm1(CEN_scm1),
        .WEN(WEN), .WEN_scm0(WEN_scm0), .WEN_scm1(WEN_scm1),
        .BEN(BEN), .BEN_scm0(BEN_scm0),
        .A(A), .A_scm0(A_scm0), .A_scm1(A_scm1),
        .D(D), .D_scm0(D_scm0),
        .Q(Q), .Q_scm0(Q_scm0), .Q_scm1(Q_scm1)
    );

    function automatic logic [31:0] init_word(input int w);
        if (w == 0) return 32'hDEAD_BEEF;
        return (32'(w) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    // bank: 0 SRAM, 1 SCM0, 2 SCM1, 3 out of window
    function automatic void tb_decode(input logic [31:0] a,
                                      output int bank, output int w);
        logic [31:0] off;
        off = a - BASE;
        w = int'(off >> 2);
        if (a < BASE || w >= 10240) bank = 3;
        else if (w < 6144) bank = 0;
        else if (w < 8192) bank = 1;
        else bank = 2;
    endfunction

    function automatic logic [112:0] exp_memif(input logic g,
        input logic [31:0] a, input logic we, input logic [3:0] be,
        input logic [31:0] d);
        logic c0, c1, c2, w0, w1, w2;
        logic [3:0] b0, b1;
        logic [12:0] a0;
        logic [10:0] a1, a2;
        logic [31:0] d0, d1;
        int bank, w;
        {c0, c1, c2, w0, w1, w2} = 6'h3F;
        b0 = 4'hF; b1 = 4'hF;
        a0 = '0; a1 = '0; a2 = '0; d0 = '0; d1 = '0;
        tb_decode(a, bank, w);
        if (g && !(bank == 3 || (bank == 2 && we))) begin
            case (bank)
                0: begin c0 = 0; w0 = ~we; b0 = ~be; a0 = 13'(w); d0 = d; end
                1: begin c1 = 0; w1 = ~we; b1 = ~be; a1 = 11'(w - 6144); d1 = d; end
                default: begin c2 = 0; w2 = ~we; a2 = 11'(w - 8192); end
            endcase
        end
        return {c0, c1, c2, w0, w1, w2, b0, b1, a0, a1, a2, d0, d1};
    endfunction

    function automatic logic [112:0] act_memif();
        return {CEN, CEN_scm0, CEN_scm1, WEN, WEN_scm0, WEN_scm1,
                BEN, BEN_scm0, A, A_scm0, A_scm1, D, D_scm0};
    endfunction

    function automatic logic [31:0] rand_addr();
        int sel;
        int w;
        sel = $urandom_range(0, 9);
        case (sel)
            0, 1, 2: w = $urandom_range(0, 15);
            3: w = 6143 - $urandom_range(0, 3);
            4, 5: w = 6144 + $urandom_range(0, 15);
            6: w = 8191 - $urandom_range(0, 3);
            7: w = 8192 + $urandom_range(0, 15);
            8: w = 10238 + $urandom_range(0, 3);
            default: return BASE - 32'(4 * $urandom_range(1, 4));
        endcase
        return BASE + 32'(w * 4) + 32'($urandom_range(0, 3));
    endfunction

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic w,
                         input logic [3:0] b, input logic [31:0] d);
        int n;
        n = 0;
        req_i = 1'b1; addr_i = a; we_i = w; be_i = b; wdata_i = d;
        do begin
            @(negedge CLK);
            n++;
        end while (!gnt_o && n < 200);
        checks++;
        if (!gnt_o) begin
            errors++;
            $display("FAIL grant_timeout: addr %h not granted in %0d cycles", a, n);
        end
        @(posedge CLK); #1;
        req_i = 1'b0;
    endtask

    // Bank models: Q returns stored word one cycle after enable.
    always @(posedge CLK) begin
        logic [31:0] t;
        if (!CEN) begin
            if (!WEN) begin
                t = sram_m[A];
                for (int k = 0; k < 4; k++)
                    if (!BEN[k]) t[8*k +: 8] = D[8*k +: 8];
                sram_m[A] = t;
            end else Q <= sram_m[A];
        end
        if (!CEN_scm0) begin
            if (!WEN_scm0) begin
                t = scm0_m[A_scm0];
                for (int k = 0; k < 4; k++)
                    if (!BEN_scm0[k]) t[8*k +: 8] = D_scm0[8*k +: 8];
                scm0_m[A_scm0] = t;
            end else Q_scm0 <= scm0_m[A_scm0];
        end
        if (!CEN_scm1 && WEN_scm1) Q_scm1 <= scm1_m[A_scm1];
    end

    initial begin
        r_ready_i = 1'b0;
        forever begin
            @(posedge CLK); #2;
            case (rdy_mode)
                0: r_ready_i = 1'b0;
                1: r_ready_i = 1'b1;
                default: r_ready_i = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Scoreboard: pop on handshake, push expected on grant.
    logic        stall_q = 1'b0;
    logic [31:0] hold_d;
    logic        hold_e;

    always @(negedge CLK) begin
        int bank, w;
        exp_t e;
        if (RST) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                checks++;
                if (!r_valid_o || r_rdata_o !== hold_d || r_err_o !== hold_e) begin
                    errors++;
                    $display("FAIL stable: got v=%b d=%h e=%b expected v=1 d=%h e=%b",
                             r_valid_o, r_rdata_o, r_err_o, hold_d, hold_e);
                end
            end
            if (r_valid_o && r_ready_i) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_resp: got d=%h e=%b expected none",
                             r_rdata_o, r_err_o);
                end else begin
                    e = exp_q.pop_front();
                    if (r_rdata_o !== e.d || r_err_o !== e.e) begin
                        errors++;
                        $display("FAIL resp: got d=%h e=%b expected d=%h e=%b",
                                 r_rdata_o, r_err_o, e.d, e.e);
                    end
                end
            end
            stall_q = r_valid_o && !r_ready_i;
            hold_d = r_rdata_o;
            hold_e = r_err_o;
            chk("memif", 128'(act_memif()),
                128'(exp_memif(gnt_o, addr_i, we_i, be_i, wdata_i)));
            if (gnt_o) begin
                tb_decode(addr_i, bank, w);
                if (bank == 3 || (bank == 2 && we_i)) begin
                    exp_q.push_back('{d: 32'h0, e: 1'b1});
                end else if (we_i) begin
                    for (int k = 0; k < 4; k++)
                        if (be_i[k]) ref_mem[w][8*k +: 8] = wdata_i[8*k +: 8];
                    exp_q.push_back('{d: 32'h0, e: 1'b0});
                end else begin
                    exp_q.push_back('{d: ref_mem[w], e: 1'b0});
                end
            end
        end
    end

    initial begin
        int n;
        logic [31:0] a;
        for (int i = 0; i < 10240; i++) ref_mem[i] = init_word(i);
        for (int i = 0; i < 6144; i++) sram_m[i] = init_word(i);
        for (int i = 0; i < 2048; i++) scm0_m[i] = init_word(6144 + i);
        for (int i = 0; i < 2048; i++) scm1_m[i] = init_word(8192 + i);
        Q = '0; Q_scm0 = '0; Q_scm1 = '0;

        RST = 1'b1;
        req_i = 1'b1; addr_i = BASE; we_i = 1'b0; be_i = 4'hF; wdata_i = '1;
        repeat (3) @(negedge CLK);
        chk("rst_gnt", 128'(gnt_o), 128'(0));
        chk("rst_valid", 128'(r_valid_o), 128'(0));
        chk("rst_rdata", 128'(r_rdata_o), 128'(0));
        chk("rst_err", 128'(r_err_o), 128'(0));
        chk("rst_memif", 128'(act_memif()),
            128'(exp_memif(1'b0, addr_i, we_i, be_i, wdata_i)));
        @(posedge CLK); #1;
        RST = 1'b0; req_i = 1'b0; rdy_mode = 1;
        @(posedge CLK); #1;

        issue(BASE, 1'b0, 4'hF, 32'h0);
        @(negedge CLK);
        chk("lat1_valid", 128'(r_valid_o), 128'(1));
        chk("lat1_rdata", 128'(r_rdata_o), 128'(32'hDEAD_BEEF));
        @(posedge CLK); #1;

        issue(BASE + 32'h6000, 1'b1, 4'b0011, 32'h1234_5678);
        issue(BASE + 32'h6000, 1'b0, 4'hF, 32'h0);
        issue(BASE + 32'h8004, 1'b1, 4'hF, 32'hCAFE_F00D);
        issue(BASE + 32'hA000, 1'b0, 4'hF, 32'h0);
        issue(BASE + 32'h8004, 1'b0, 4'hF, 32'h0);
        issue(BASE - 32'd4, 1'b0, 4'hF, 32'h0);
        issue(BASE + 32'h5FFC, 1'b0, 4'hF, 32'h0);
        issue(BASE + 32'h9FFF, 1'b0, 4'hF, 32'h0);

        repeat (3) @(posedge CLK);
        #1 rdy_mode = 0;
        @(posedge CLK); #1;
        issue(BASE + 32'h10, 1'b0, 4'hF, 32'h0);
        issue(BASE + 32'h6010, 1'b0, 4'hF, 32'h0);
        req_i = 1'b1; addr_i = BASE + 32'h8; we_i = 1'b0; be_i = 4'hF;
        @(negedge CLK);
        chk("full_gnt0", 128'(gnt_o), 128'(0));
        @(negedge CLK);
        chk("full_gnt1", 128'(gnt_o), 128'(0));
        @(posedge CLK); #1;
        rdy_mode = 1;
        @(negedge CLK);
        chk("pop_cycle_gnt", 128'(gnt_o), 128'(1));
        @(posedge CLK); #1;
        req_i = 1'b0;

        repeat (4) @(posedge CLK);
        #1 rdy_mode = 0;
        @(posedge CLK); #1;
        issue(BASE + 32'h4, 1'b0, 4'hF, 32'h0);
        issue(BASE + 32'h6004, 1'b0, 4'hF, 32'h0);
        RST = 1'b1;
        req_i = 1'b1; addr_i = BASE; we_i = 1'b0;
        #1;
        chk("mid_rst_valid", 128'(r_valid_o), 128'(0));
        chk("mid_rst_gnt", 128'(gnt_o), 128'(0));
        chk("mid_rst_rdata", 128'(r_rdata_o), 128'(0));
        chk("mid_rst_memif", 128'(act_memif()),
            128'(exp_memif(1'b0, addr_i, we_i, be_i, wdata_i)));
        exp_q.delete();
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0; req_i = 1'b0; rdy_mode = 1;
        repeat (6) begin
            @(negedge CLK);
            chk("no_ghost", 128'(r_valid_o), 128'(0));
        end
        @(posedge CLK); #1;
        issue(BASE + 32'h4, 1'b0, 4'hF, 32'h0);

        rdy_mode = 2;
        for (int i = 0; i < 300; i++) begin
            a = rand_addr();
            issue(a, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge CLK); #1;
            end
        end

        rdy_mode = 1;
        n = 0;
        while ((exp_q.size() != 0 || r_valid_o) && n < 50) begin
            @(negedge CLK);
            n++;
        end
        chk("drain_empty", 128'(exp_q.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
